// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, h/v counters, sync/blank decode and frame-buffer address.
// Optional completed-frame counter built when VGA_TIMING_FRAME_CNT_EN is defined; otherwise frame_count is 0.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 10,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              pixel_clk,
  output logic              pixel_tick,
  output logic [CNT_W-1:0]  hcount,
  output logic [CNT_W-1:0]  vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              line_end,
  output logic              frame_end,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  end

  // Decode is purely combinational from the count registers so every marker is aligned with its count.
  always_comb begin
    pixel_tick = enable && (div == DIV_LAST);
    line_end   = (hcount == H_LAST);
    frame_end  = line_end && (vcount == V_LAST);
    active     = (hcount < H_ACT) && (vcount < V_ACT);
    hsync      = ((hcount >= H_SS) && (hcount < H_SE)) ? HS_ON : ~HS_ON;
    vsync      = ((vcount >= V_SS) && (vcount < V_SE)) ? VS_ON : ~VS_ON;
  end

  // pixel_clk is loaded from div_next so it always equals (div >= CLK_DIV/2) for the current div.
  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      pixel_clk <= 1'b0;
      hcount    <= '0;
      vcount    <= '0;
      addr      <= '0;
    end else if (enable) begin
      div       <= div_next;
      pixel_clk <= (div_next >= DIV_HALF);
      if (pixel_tick) begin
        if (frame_end)
          addr <= '0;
        else if (active)
          addr <= addr + ADDR_W'(1);
        if (line_end) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
        end else begin
          hcount <= hcount + CNT_W'(1);
        end
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= '0;
    else if (pixel_tick && frame_end)
      frame_cnt <= frame_cnt + 16'd1;
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a small raster instance with active-high syncs.
module tb_vga_timing_gen;

  localparam int CD = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable;

  always #5 clk = ~clk;

  logic        d_pclk, d_tick, d_hs, d_vs, d_act, d_le, d_fe;
  logic [9:0]  d_hc, d_vc;
  logic [18:0] d_addr;
  logic [15:0] d_fc;

  logic        s_pclk, s_tick, s_hs, s_vs, s_act, s_le, s_fe;
  logic [4:0]  s_hc, s_vc;
  logic [5:0]  s_addr;
  logic [15:0] s_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .enable(enable),
    .pixel_clk(d_pclk), .pixel_tick(d_tick),
    .hcount(d_hc), .vcount(d_vc), .hsync(d_hs), .vsync(d_vs),
    .active(d_act), .line_end(d_le), .frame_end(d_fe),
    .addr(d_addr), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1), .VS_POL(1), .CNT_W(5), .ADDR_W(6)
  ) u_sm (
    .clk(clk), .rst(rst), .enable(enable),
    .pixel_clk(s_pclk), .pixel_tick(s_tick),
    .hcount(s_hc), .vcount(s_vc), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .line_end(s_le), .frame_end(s_fe),
    .addr(s_addr), .frame_count(s_fc)
  );

  typedef struct {
    int hc, vc, hs, vs, act, le, fe, ad, fc, tk, pc;
  } exp_t;

  exp_t q_def[$];
  exp_t q_sm[$];

  int checks = 0;
  int errors = 0;
  int n = 0;   // pixel ticks since reset
  int d = 0;   // divider phase

  // Position derived from the absolute tick count rather than by stepping counters.
  function automatic exp_t model(input int nt, input int dv, input logic en,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input int hp, input int vp);
    exp_t m;
    int ht, vt, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h = nt % ht;
    v = (nt / ht) % vt;
    m.hc  = h;
    m.vc  = v;
    m.hs  = (h >= ha + hf && h < ha + hf + hs) ? hp : 1 - hp;
    m.vs  = (v >= va + vf && v < va + vf + vs) ? vp : 1 - vp;
    m.act = (h < ha && v < va) ? 1 : 0;
    m.le  = (h == ht - 1) ? 1 : 0;
    m.fe  = (h == ht - 1 && v == vt - 1) ? 1 : 0;
    m.ad  = (v < va) ? v * ha + ((h < ha) ? h : ha) : ha * va;
`ifdef VGA_TIMING_FRAME_CNT_EN
    m.fc  = (nt / (ht * vt)) % 65536;
`else
    m.fc  = 0;
`endif
    m.tk  = (en && dv == CD - 1) ? 1 : 0;
    m.pc  = (dv >= CD / 2) ? 1 : 0;
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input int hc, input int vc,
                     input int hs, input int vs, input int act, input int le,
                     input int fe, input int ad, input int fc, input int tk, input int pc);
    chk({tag, "_hcount"}, hc, e.hc);
    chk({tag, "_vcount"}, vc, e.vc);
    chk({tag, "_hsync"}, hs, e.hs);
    chk({tag, "_vsync"}, vs, e.vs);
    chk({tag, "_active"}, act, e.act);
    chk({tag, "_line_end"}, le, e.le);
    chk({tag, "_frame_end"}, fe, e.fe);
    chk({tag, "_addr"}, ad, e.ad);
    chk({tag, "_frame_count"}, fc, e.fc);
    chk({tag, "_pixel_tick"}, tk, e.tk);
    chk({tag, "_pixel_clk"}, pc, e.pc);
  endtask

  // Monitor: one expectation per cycle per instance, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q_def.size() > 0) begin
      e = q_def.pop_front();
      cmp("def", e, int'(d_hc), int'(d_vc), int'(d_hs), int'(d_vs), int'(d_act),
          int'(d_le), int'(d_fe), int'(d_addr), int'(d_fc), int'(d_tick), int'(d_pclk));
    end
    if (q_sm.size() > 0) begin
      e = q_sm.pop_front();
      cmp("sm", e, int'(s_hc), int'(s_vc), int'(s_hs), int'(s_vs), int'(s_act),
          int'(s_le), int'(s_fe), int'(s_addr), int'(s_fc), int'(s_tick), int'(s_pclk));
    end
  end

  task automatic drive(input logic r, input logic e);
    rst    = r;
    enable = e;
    q_def.push_back(model(n, d, e, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0));
    q_sm.push_back(model(n, d, e, 8, 2, 3, 3, 6, 2, 2, 2, 1, 1));
    @(posedge clk);
    if (r) begin
      n = 0;
      d = 0;
    end else if (e) begin
      if (d == CD - 1) n++;
      d = (d + 1) % CD;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    // Two full default lines plus 300 pixels; the small raster covers several frames meanwhile.
    while (n < 1900) drive(1'b0, 1'b1);
    chk("def_hcount_at_freeze", int'(d_hc), 300);
    chk("def_vcount_at_freeze", int'(d_vc), 2);
    chk("def_addr_at_freeze", int'(d_addr), 1580);
    chk("def_hsync_at_freeze", int'(d_hs), 1);
    chk("sm_hcount_at_freeze", int'(s_hc), 12);
    chk("sm_vcount_at_freeze", int'(s_vc), 10);
    chk("sm_hsync_at_freeze", int'(s_hs), 1);
    chk("sm_vsync_at_freeze", int'(s_vs), 0);
    chk("sm_addr_at_freeze", int'(s_addr), 48);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("sm_frame_count_at_freeze", int'(s_fc), 9);
`else
    chk("sm_frame_count_at_freeze", int'(s_fc), 0);
`endif
    repeat (10) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
    while (n < 2100) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (600) drive(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q_def.size() + q_sm.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
